btn_event_ctrl: RTL and testbench
=================================

# btn_event_ctrl

- Event controller between the per-button debouncers and the user logic.
- Takes N debounced button levels and turns each into discrete events: press, release, long-press and auto-repeat.
- Shares a single event queue among the N buttons using a round-robin arbiter.
- Presents the queue through a valid/ready interface, so the consumer reads one event at a time.

## Interface
- N, 4: number of buttons, 2..8.
- LONG_CYCLES, 8: cycles from PRESS event to LONG event, >=2.
- REPEAT_CYCLES, 4: cycles between REPEAT events, >=2.
- DEPTH, 4: event FIFO depth, power of two, >=2.
- clk  in  1  clock, single domain; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- btn  in  N  debounced button levels, already synchronous to clk.
- evt_ready  in  1  consumer accepts the head event.
- evt_valid  out  1  FIFO non-empty.
- evt_id  out  clog2(N), min 1  button index of the head event.
- evt_code  out  2  0=PRESS, 1=RELEASE, 2=LONG, 3=REPEAT.
- evt_drop  out  1  one-cycle pulse when a generated event is discarded.

## Operation
- **Edge detection:** btn_prev register, reset to 0.
  - rise = btn & ~btn_prev; fall = ~btn & btn_prev.
  - A button already held high when reset is released produces a PRESS.
- **Per-button FSM:** IDLE, PRESSED, HELD, plus a timer counting to max(LONG_CYCLES, REPEAT_CYCLES).
  - IDLE + rise: generate PRESS, go to PRESSED, timer=0.
  - PRESSED: timer increments each cycle. When timer==LONG_CYCLES-1, generate LONG, go to HELD, timer=0.
  - HELD: timer increments each cycle. When timer==REPEAT_CYCLES-1, generate REPEAT (macro-dependent), timer=0.
  - PRESSED/HELD + fall: generate RELEASE, go to IDLE. Fall takes precedence over a LONG/REPEAT due in the same cycle.
- **Pending slot:** one per button, holding valid + code.
  - A generated event loads the slot if it is empty, or if it is being granted in that same cycle.
  - Otherwise the event is discarded and evt_drop pulses. Multiple drops in one cycle give a single pulse.
- **Arbiter:**
  - Grants the lowest index >= ptr with a valid pending slot, wrapping at N.
  - Grants only when FIFO count < DEPTH. There is no bypass: a full FIFO blocks even when a pop happens in the same cycle.
  - On a grant: the slot is pushed to the FIFO, the slot is cleared, and ptr becomes (grant+1) mod N.
  - ptr resets to 0.
- **FIFO:**
  - pop when evt_valid & evt_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - evt_id/evt_code show the head entry directly from storage and hold stable while evt_valid & ~evt_ready.
- **Reset:**
  - All FSMs go to IDLE and the timers clear.
  - Slots clear, FIFO empties, ptr=0.
  - Outputs: evt_valid=0, evt_id=0, evt_code=0, evt_drop=0.
  - Reset mid-hold discards all queued events. After reset, a still-held button produces a fresh PRESS.

## Timing
- btn[i] rises before edge E0: slot loaded at E0, FIFO write at E1, evt_valid=1 after E1 (empty FIFO, no contention).
- LONG slot load happens LONG_CYCLES edges after the PRESS slot load.
- REPEATs follow every REPEAT_CYCLES edges.
- Arbiter throughput: one event per cycle; FIFO output: one per cycle with evt_ready held high.
- evt_drop is asserted in the cycle after the discarding edge, for exactly one cycle.

## Configuration
- BTN_REPEAT_EN defined: HELD generates REPEAT events as above.
- BTN_REPEAT_EN undefined:
  - HELD generates no events until release, and code 3 never appears.
  - The HELD timer logic is removed.

## Test plan
All scenarios use N=4, LONG=8, REPEAT=4, DEPTH=4, BTN_REPEAT_EN defined unless stated otherwise.
- Single press: btn[2] high at E0, low at E0+20, evt_ready=1 -> slot loads PRESS@E0, LONG@E8, REPEAT@E12, E16, RELEASE@E20. No REPEAT@E20. id=2 throughout, 5 events total.
- Simultaneous presses: btn[0] and btn[3] rise together, ptr=0 -> PRESS id0, then PRESS id3 on the next cycle, ptr=0 afterwards.
- Backpressure and drops:
  - evt_ready=0; press btn0..3, then release all, then press btn0 again.
  - Required: FIFO holds P0..P3, the slots hold R0..R3, and the second btn0 press gives one evt_drop pulse.
  - Then evt_ready=1 -> P0,P1,P2,P3,R0,R1,R2,R3, one per cycle, then evt_valid=0.
- Full-FIFO push/pop: FIFO full and slot 1 pending; evt_ready=1 for 1 cycle -> pop happens, no push that cycle, push on the next cycle.
- Reset mid-hold: btn[1] held, rst pulsed at E10 with 3 events queued -> evt_valid=0 the next cycle, then PRESS id1 appears 2 cycles after rst deasserts.
- Build without BTN_REPEAT_EN: btn[0] held 30 cycles -> PRESS, LONG, RELEASE only; code 3 never observed.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns N debounced button levels into PRESS/RELEASE/LONG/REPEAT
// events, arbitrates them round-robin into a shared FIFO and presents the FIFO
// head over a valid/ready interface.
// Build option: define BTN_REPEAT_EN to enable REPEAT events while a button is held;
// without it a held button is silent until release and the HELD timer is removed.
module btn_event_ctrl #(
    parameter int unsigned N             = 4,
    parameter int unsigned LONG_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned DEPTH         = 4,
    localparam int unsigned IW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  btn,
    input  logic          evt_ready,
    output logic          evt_valid,
    output logic [IW-1:0] evt_id,
    output logic [1:0]    evt_code,
    output logic          evt_drop
);

    localparam int unsigned MaxCyc = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW     = $clog2(MaxCyc);
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CW     = PW + 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPressed = 2'd1;
    localparam logic [1:0] StHeld    = 2'd2;

    localparam logic [1:0] CodePress   = 2'd0;
    localparam logic [1:0] CodeRelease = 2'd1;
    localparam logic [1:0] CodeLong    = 2'd2;
`ifdef BTN_REPEAT_EN
    localparam logic [1:0] CodeRepeat  = 2'd3;
`endif

    logic [N-1:0]    btn_prev;
    logic [N-1:0]    rise;
    logic [N-1:0]    fall;
    logic [1:0]      state_q [N];
    logic [1:0]      state_d [N];
    logic [TW-1:0]   timer_q [N];
    logic [TW-1:0]   timer_d [N];
    logic [N-1:0]    gen_valid;
    logic [1:0]      gen_code [N];

    logic [N-1:0]    slot_valid_q;
    logic [1:0]      slot_code_q [N];
    logic [N-1:0]    drop_vec;
    logic            drop_q;

    logic [IW-1:0]   ptr_q;
    logic [N-1:0]    grant;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;

    logic [IW-1:0]   mem_id_q   [DEPTH];
    logic [1:0]      mem_code_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    assign rise = btn & ~btn_prev;
    assign fall = ~btn & btn_prev;

    // Per-button FSM next state and event generation; a release beats a due LONG/REPEAT.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i]   = state_q[i];
            timer_d[i]   = timer_q[i];
            gen_valid[i] = 1'b0;
            gen_code[i]  = CodePress;
            case (state_q[i])
                StIdle: begin
                    if (rise[i]) begin
                        gen_valid[i] = 1'b1;
                        gen_code[i]  = CodePress;
                        state_d[i]   = StPressed;
                        timer_d[i]   = '0;
                    end
                end
                StPressed: begin
                    if (fall[i]) begin
                        gen_valid[i] = 1'b1;
                        gen_code[i]  = CodeRelease;
                        state_d[i]   = StIdle;
                        timer_d[i]   = '0;
                    end else if (timer_q[i] == TW'(LONG_CYCLES - 1)) begin
                        gen_valid[i] = 1'b1;
                        gen_code[i]  = CodeLong;
                        state_d[i]   = StHeld;
                        timer_d[i]   = '0;
                    end else begin
                        timer_d[i]   = timer_q[i] + TW'(1);
                    end
                end
                StHeld: begin
                    if (fall[i]) begin
                        gen_valid[i] = 1'b1;
                        gen_code[i]  = CodeRelease;
                        state_d[i]   = StIdle;
                        timer_d[i]   = '0;
`ifdef BTN_REPEAT_EN
                    end else if (timer_q[i] == TW'(REPEAT_CYCLES - 1)) begin
                        gen_valid[i] = 1'b1;
                        gen_code[i]  = CodeRepeat;
                        timer_d[i]   = '0;
                    end else begin
                        timer_d[i]   = timer_q[i] + TW'(1);
`endif
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // Round-robin grant starting at ptr; only when the FIFO has room (no pop bypass).
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (count_q < CW'(DEPTH)) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = IW'((32'(ptr_q) + k) % N);
                if (!grant_any && slot_valid_q[cand]) begin
                    grant_any       = 1'b1;
                    grant[cand]     = 1'b1;
                    grant_idx       = cand;
                end
            end
        end
    end

    // An event is lost when its slot is still occupied and not leaving this cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            drop_vec[i] = gen_valid[i] & slot_valid_q[i] & ~grant[i];
        end
    end

    assign push      = grant_any;
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign evt_id    = mem_id_q[rd_q];
    assign evt_code  = mem_code_q[rd_q];
    assign evt_drop  = drop_q;

    // Edge history, FSM state/timers, pending slots, arbiter pointer and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev     <= '0;
            slot_valid_q <= '0;
            ptr_q        <= '0;
            drop_q       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                state_q[i]     <= StIdle;
                timer_q[i]     <= '0;
                slot_code_q[i] <= '0;
            end
        end else begin
            btn_prev <= btn;
            drop_q   <= |drop_vec;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                if (gen_valid[i] && (!slot_valid_q[i] || grant[i])) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_code_q[i]  <= gen_code[i];
                end else if (grant[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
            end
        end
    end

    // Event FIFO; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                mem_id_q[d]   <= '0;
                mem_code_q[d] <= '0;
            end
        end else begin
            if (push) begin
                mem_id_q[wr_q]   <= grant_idx;
                mem_code_q[wr_q] <= slot_code_q[grant_idx];
                wr_q             <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl (N=4, LONG=8, REPEAT=4, DEPTH=4).
// Expectations follow BTN_REPEAT_EN when the macro is defined for the build.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'h0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [1:0] evt_code;
    logic       evt_drop;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int drop_cnt = 0;

    // Popped events with the cycle stamp at which they were presented.
    logic [1:0] q_id[$];
    logic [1:0] q_code[$];
    int         q_stamp[$];

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .N             (4),
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .DEPTH         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_code  (evt_code),
        .evt_drop  (evt_drop)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            q_id.push_back(evt_id);
            q_code.push_back(evt_code);
            q_stamp.push_back(cyc);
        end
        if (evt_drop) drop_cnt = drop_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = 4'h0;
        evt_ready = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
        n_cmp++; if (evt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d want=0", evt_id); end
        n_cmp++; if (evt_code !== 2'd0) begin n_fail++; $display("FAIL reset_code got=%0d want=0", evt_code); end
        n_cmp++; if (evt_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b want=0", evt_drop); end
        rst = 1'b0;
        tick(3);
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b want=0", evt_valid); end
    endtask

    task automatic test_single_press();
        int base, db, c0;
        logic [1:0] eid[$];
        logic [1:0] ecode[$];
        int est[$];
`ifdef BTN_REPEAT_EN
        eid = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        ecode = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd1};
        est = '{1, 9, 13, 17, 21};
`else
        eid = '{2'd2, 2'd2, 2'd2};
        ecode = '{2'd0, 2'd2, 2'd1};
        est = '{1, 9, 21};
`endif
        do_reset();
        evt_ready = 1'b1;
        base = q_id.size();
        db = drop_cnt;
        btn = 4'b0100;
        tick(1);
        c0 = cyc;
        tick(19);
        btn = 4'b0000;
        tick(6);
        n_cmp++;
        if (q_id.size() - base != ecode.size()) begin
            n_fail++; $display("FAIL single_count got=%0d want=%0d", q_id.size() - base, ecode.size());
        end
        for (int j = 0; j < ecode.size(); j++) begin
            n_cmp++;
            if (base + j >= q_id.size()) begin
                n_fail++; $display("FAIL single_evt%0d missing want id=%0d code=%0d", j, eid[j], ecode[j]);
            end else if (q_id[base+j] !== eid[j] || q_code[base+j] !== ecode[j] ||
                         q_stamp[base+j] != c0 + est[j]) begin
                n_fail++;
                $display("FAIL single_evt%0d got id=%0d code=%0d t=%0d want id=%0d code=%0d t=%0d", j,
                         q_id[base+j], q_code[base+j], q_stamp[base+j] - c0, eid[j], ecode[j], est[j]);
            end
        end
        n_cmp++; if (drop_cnt - db != 0) begin n_fail++; $display("FAIL single_drops got=%0d want=0", drop_cnt - db); end
    endtask

    task automatic test_simultaneous();
        int base, c0;
        logic [1:0] eid[$];
        logic [1:0] ecode[$];
        int est[$];
        eid = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        ecode = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1};
        est = '{1, 2, 9, 10, 12, 13};
        do_reset();
        evt_ready = 1'b1;
        base = q_id.size();
        btn = 4'b1001;
        tick(1);
        c0 = cyc;
        tick(10);
        btn = 4'b0000;
        tick(6);
        n_cmp++;
        if (q_id.size() - base != ecode.size()) begin
            n_fail++; $display("FAIL simul_count got=%0d want=%0d", q_id.size() - base, ecode.size());
        end
        for (int j = 0; j < ecode.size(); j++) begin
            n_cmp++;
            if (base + j >= q_id.size()) begin
                n_fail++; $display("FAIL simul_evt%0d missing want id=%0d code=%0d", j, eid[j], ecode[j]);
            end else if (q_id[base+j] !== eid[j] || q_code[base+j] !== ecode[j] ||
                         q_stamp[base+j] != c0 + est[j]) begin
                n_fail++;
                $display("FAIL simul_evt%0d got id=%0d code=%0d t=%0d want id=%0d code=%0d t=%0d", j,
                         q_id[base+j], q_code[base+j], q_stamp[base+j] - c0, eid[j], ecode[j], est[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base, db, c0;
        do_reset();
        base = q_id.size();
        db = drop_cnt;
        btn = 4'b1111;
        tick(1);
        c0 = cyc;
        tick(5);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_code !== 2'd0) begin
            n_fail++; $display("FAIL bp_head got v=%b id=%0d code=%0d want v=1 id=0 code=0", evt_valid, evt_id, evt_code);
        end
        btn = 4'b0000;
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_code !== 2'd0) begin
            n_fail++; $display("FAIL bp_hold got v=%b id=%0d code=%0d want v=1 id=0 code=0", evt_valid, evt_id, evt_code);
        end
        btn = 4'b0001;
        tick(1);
        n_cmp++; if (evt_drop !== 1'b1) begin n_fail++; $display("FAIL bp_drop_pulse got=%b want=1", evt_drop); end
        evt_ready = 1'b1;
        tick(8);
        n_cmp++;
        if (q_id.size() - base != 8) begin
            n_fail++; $display("FAIL bp_count got=%0d want=8", q_id.size() - base);
        end
        for (int j = 0; j < 8; j++) begin
            logic [1:0] wid;
            logic [1:0] wcode;
            wid = 2'(j % 4);
            wcode = (j < 4) ? 2'd0 : 2'd1;
            n_cmp++;
            if (base + j >= q_id.size()) begin
                n_fail++; $display("FAIL bp_evt%0d missing want id=%0d code=%0d", j, wid, wcode);
            end else if (q_id[base+j] !== wid || q_code[base+j] !== wcode || q_stamp[base+j] != c0 + 7 + j) begin
                n_fail++;
                $display("FAIL bp_evt%0d got id=%0d code=%0d t=%0d want id=%0d code=%0d t=%0d", j,
                         q_id[base+j], q_code[base+j], q_stamp[base+j] - c0, wid, wcode, 7 + j);
            end
        end
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b want=0", evt_valid); end
        n_cmp++; if (drop_cnt - db != 1) begin n_fail++; $display("FAIL bp_drops got=%0d want=1", drop_cnt - db); end
    endtask

    task automatic test_full_push_pop();
        int base, db, c0;
        logic [1:0] eid[$];
        logic [1:0] ecode[$];
        int est[$];
        eid = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
        ecode = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        est = '{5, 7, 8, 9, 10};
        do_reset();
        base = q_id.size();
        db = drop_cnt;
        btn = 4'b0101;
        tick(1);
        c0 = cyc;
        tick(1);
        btn = 4'b0000;
        tick(3);
        btn = 4'b0010;
        tick(1);
        // FIFO full, slot1 holds PRESS; pop once while btn1 releases
        evt_ready = 1'b1;
        btn = 4'b0000;
        tick(1);
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_code !== 2'd0) begin
            n_fail++; $display("FAIL ff_head got v=%b id=%0d code=%0d want v=1 id=2 code=0", evt_valid, evt_id, evt_code);
        end
        n_cmp++; if (evt_drop !== 1'b1) begin n_fail++; $display("FAIL ff_drop_pulse got=%b want=1", evt_drop); end
        tick(1);
        evt_ready = 1'b1;
        tick(6);
        n_cmp++;
        if (q_id.size() - base != ecode.size()) begin
            n_fail++; $display("FAIL ff_count got=%0d want=%0d", q_id.size() - base, ecode.size());
        end
        for (int j = 0; j < ecode.size(); j++) begin
            n_cmp++;
            if (base + j >= q_id.size()) begin
                n_fail++; $display("FAIL ff_evt%0d missing want id=%0d code=%0d", j, eid[j], ecode[j]);
            end else if (q_id[base+j] !== eid[j] || q_code[base+j] !== ecode[j] ||
                         q_stamp[base+j] != c0 + est[j]) begin
                n_fail++;
                $display("FAIL ff_evt%0d got id=%0d code=%0d t=%0d want id=%0d code=%0d t=%0d", j,
                         q_id[base+j], q_code[base+j], q_stamp[base+j] - c0, eid[j], ecode[j], est[j]);
            end
        end
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ff_empty got=%b want=0", evt_valid); end
        n_cmp++; if (drop_cnt - db != 1) begin n_fail++; $display("FAIL ff_drops got=%0d want=1", drop_cnt - db); end
    endtask

    task automatic test_reset_mid_hold();
        int db;
        do_reset();
        db = drop_cnt;
        btn = 4'b0110;
        tick(3);
        btn = 4'b0010;
        tick(3);
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL rmh_queued got=%b want=1", evt_valid); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_code !== 2'd0) begin
            n_fail++; $display("FAIL rmh_cleared got v=%b id=%0d code=%0d want v=0 id=0 code=0", evt_valid, evt_id, evt_code);
        end
        tick(1);
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_wait got=%b want=0", evt_valid); end
        tick(1);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_code !== 2'd0) begin
            n_fail++; $display("FAIL rmh_repress got v=%b id=%0d code=%0d want v=1 id=1 code=0", evt_valid, evt_id, evt_code);
        end
        n_cmp++; if (drop_cnt - db != 0) begin n_fail++; $display("FAIL rmh_drops got=%0d want=0", drop_cnt - db); end
    endtask

    task automatic test_long_hold();
        int base, c0, nrep, want_rep;
        logic [1:0] ecode[$];
        int est[$];
`ifdef BTN_REPEAT_EN
        ecode = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
        est = '{1, 9, 13, 17, 21, 25, 29, 31};
        want_rep = 5;
`else
        ecode = '{2'd0, 2'd2, 2'd1};
        est = '{1, 9, 31};
        want_rep = 0;
`endif
        do_reset();
        evt_ready = 1'b1;
        base = q_id.size();
        btn = 4'b0001;
        tick(1);
        c0 = cyc;
        tick(29);
        btn = 4'b0000;
        tick(5);
        n_cmp++;
        if (q_id.size() - base != ecode.size()) begin
            n_fail++; $display("FAIL hold_count got=%0d want=%0d", q_id.size() - base, ecode.size());
        end
        nrep = 0;
        for (int j = base; j < q_code.size(); j++) if (q_code[j] == 2'd3) nrep++;
        n_cmp++; if (nrep != want_rep) begin n_fail++; $display("FAIL hold_repeats got=%0d want=%0d", nrep, want_rep); end
        for (int j = 0; j < ecode.size(); j++) begin
            n_cmp++;
            if (base + j >= q_id.size()) begin
                n_fail++; $display("FAIL hold_evt%0d missing want code=%0d", j, ecode[j]);
            end else if (q_id[base+j] !== 2'd0 || q_code[base+j] !== ecode[j] ||
                         q_stamp[base+j] != c0 + est[j]) begin
                n_fail++;
                $display("FAIL hold_evt%0d got id=%0d code=%0d t=%0d want id=0 code=%0d t=%0d", j,
                         q_id[base+j], q_code[base+j], q_stamp[base+j] - c0, ecode[j], est[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid_hold();
        test_long_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
